// File: rtl/quad_encoder_counter.sv
// rtl/quad_encoder_counter.sv - quadrature encoder synchroniser, debouncer, x4 decoder and up/down counter
module quad_encoder_counter #(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 4,
    parameter int SATURATE   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             step_up,
    output logic             step_dn,
    output logic             err
);
    localparam int               CW     = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0]    C_LAST = CW'(FILTER_LEN - 1);
    localparam logic [WIDTH-1:0] V_MAX  = '1;

    // Bit 1 carries phase A and bit 0 phase B, so each vector reads as the {a,b} state.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [1:0]    prev;
    logic [CW-1:0] dcnt [2];

    logic is_up;
    logic is_dn;
    logic is_err;

    function automatic logic [1:0] up_next(input logic [1:0] s);
        case (s)
            2'b00:   up_next = 2'b01;
            2'b01:   up_next = 2'b11;
            2'b11:   up_next = 2'b10;
            default: up_next = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
        end
    end

    // A pin only flips after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == C_LAST) begin
                    filt[i] <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CW'(1);
                end
            end
        end
    end

    // up_next never maps a state to itself, so an unchanged state decodes as neither direction.
    always_comb begin
        is_up  = (filt == up_next(prev));
        is_dn  = (prev == up_next(filt));
        is_err = ((filt ^ prev) == 2'b11);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= '0;
            value   <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= 1'b0;
        end else begin
            prev    <= filt;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= is_err;
            if (clear) begin
                value <= '0;
            end else if (is_up) begin
                step_up <= 1'b1;
                if (!((SATURATE != 0) && (value == V_MAX))) value <= value + WIDTH'(1);
            end else if (is_dn) begin
                step_dn <= 1'b1;
                if (!((SATURATE != 0) && (value == '0))) value <= value - WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_quad_encoder_counter.sv
// tb/tb_quad_encoder_counter.sv - scoreboard bench for quad_encoder_counter, saturating and wrapping copies
module tb_quad_encoder_counter;
    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       clear;
    logic [7:0] val_s, val_w;
    logic       su_s, sd_s, er_s, su_w, sd_w, er_w;

    always #5 clk = ~clk;

    quad_encoder_counter #(.WIDTH(8), .FILTER_LEN(4), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .value(val_s), .step_up(su_s), .step_dn(sd_s), .err(er_s)
    );

    quad_encoder_counter #(.WIDTH(8), .FILTER_LEN(4), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .value(val_w), .step_up(su_w), .step_dn(sd_w), .err(er_w)
    );

    typedef struct {
        int         cyc;
        logic       up;
        logic       dn;
        logic       er;
        logic [7:0] vs;
        logic [7:0] vw;
    } exp_t;

    typedef struct {
        logic [1:0] pins;
        int         hold;
        logic       up;
        logic       dn;
        logic       er;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[$];
    int         n_total = 0;
    int         n_pass  = 0;
    int         cyc     = 0;
    logic [7:0] m_s     = 8'd0;
    logic [7:0] m_w     = 8'd0;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Pins change on a falling edge; the registered result appears 7 rising edges later.
    task automatic apply(input logic [1:0] pins, input int hold, input logic up, input logic dn, input logic er);
        exp_t e;
        {enc_a, enc_b} = pins;
        if (up) begin
            m_s = (m_s == 8'hFF) ? m_s : m_s + 8'd1;
            m_w = m_w + 8'd1;
        end else if (dn) begin
            m_s = (m_s == 8'h00) ? m_s : m_s - 8'd1;
            m_w = m_w - 8'd1;
        end
        e.cyc = cyc + 7;
        e.up  = up;
        e.dn  = dn;
        e.er  = er;
        e.vs  = m_s;
        e.vw  = m_w;
        if (up || dn || er) sb.push_back(e);
        repeat (hold) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (su_s || sd_s || er_s || su_w || sd_w || er_w)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {su_s, sd_s, er_s, su_w, sd_w, er_w}, 0);
            end else begin
                e = sb.pop_front();
                check("evt_cycle", cyc, e.cyc);
                check("evt_step_up_sat", su_s, e.up);
                check("evt_step_dn_sat", sd_s, e.dn);
                check("evt_err_sat", er_s, e.er);
                check("evt_step_up_wrap", su_w, e.up);
                check("evt_step_dn_wrap", sd_w, e.dn);
                check("evt_err_wrap", er_w, e.er);
                check("evt_value_sat", val_s, e.vs);
                check("evt_value_wrap", val_w, e.vw);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int wait_cnt;
        reset = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value_sat", val_s, 0);
        check("rst_value_wrap", val_w, 0);
        check("rst_pulses", {su_s, sd_s, er_s, su_w, sd_w, er_w}, 0);
        check("rst_filt", u_sat.filt, 0);
        reset = 1'b0;

        // full up cycle, 4-cycle glitch accepted, illegal double-pin jumps
        tbl.push_back('{2'b01, 10, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{2'b11, 10, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 10, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{2'b00, 10, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{2'b10,  4, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{2'b00, 10, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{2'b11, 10, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 10, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{2'b01, 10, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 10, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{2'b01, 10, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 10, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i].pins, tbl[i].hold, tbl[i].up, tbl[i].dn, tbl[i].er);
        check("table_value_sat", val_s, 4);

        // 3-sample glitch on A must never reach the filtered pin
        apply(2'b10, 3, 1'b0, 1'b0, 1'b0);
        apply(2'b00, 10, 1'b0, 1'b0, 1'b0);
        check("glitch_filt", u_sat.filt, 0);
        check("glitch_value", val_s, 4);

        // climb to 10 (ending in state 11), then clear lands on the next up step
        for (int i = 0; i < 6; i++) apply(gray[(i + 1) % 4], 8, 1'b1, 1'b0, 1'b0);
        check("pre_clear_value", val_s, 10);
        {enc_a, enc_b} = 2'b10;
        m_s = 8'd0;
        m_w = 8'd0;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_value_sat", val_s, 0);
        check("clear_value_wrap", val_w, 0);
        check("clear_no_step", su_s, 0);
        repeat (8) @(negedge clk);

        // saturation at 255 / wrap past 255, then saturation at 0 / wrap below 0
        idx = 3;
        for (int i = 0; i < 260; i++) begin
            idx = (idx + 1) % 4;
            apply(gray[idx], 5, 1'b1, 1'b0, 1'b0);
        end
        repeat (8) @(negedge clk);
        check("sat_high_value", val_s, 255);
        check("wrap_high_value", val_w, 4);
        for (int i = 0; i < 260; i++) begin
            idx = (idx + 3) % 4;
            apply(gray[idx], 5, 1'b0, 1'b1, 1'b0);
        end
        repeat (8) @(negedge clk);
        check("sat_low_value", val_s, 0);
        check("wrap_low_value", val_w, 0);

        // reset in the middle of a debounce count on pin B
        apply(2'b00, 10, 1'b1, 1'b0, 1'b0);
        {enc_a, enc_b} = 2'b01;
        repeat (3) @(negedge clk);
        check("partial_count", u_sat.dcnt[0], 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_value_sat", val_s, 0);
        check("midrst_value_wrap", val_w, 0);
        check("midrst_pulses", {su_s, sd_s, er_s, su_w, sd_w, er_w}, 0);
        check("midrst_count", u_sat.dcnt[0], 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_s = 8'd0;
        m_w = 8'd0;
        apply(2'b01, 12, 1'b1, 1'b0, 1'b0);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("queue_drained", sb.size(), 0);
        check("final_value_sat", val_s, 1);
        check("final_value_wrap", val_w, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
